// File: rtl/ysyx_22040127_mem_stage_pkg.sv
// Shared widths, size encodings, FSM states and store-lane helpers for the MEM stage.
package ysyx_22040127_mem_stage_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned WB_CORE_W = PC_W + 1 + RD_W + XLEN;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;
  localparam logic [1:0] SizeD = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StDone,
    StDrain
  } mem_state_e;

  function automatic logic [7:0] store_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SizeB:   m = 8'h01;
      SizeH:   m = 8'h03;
      SizeW:   m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << offset;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size,
                                                  input logic [XLEN-1:0] data);
    logic [XLEN-1:0] v;
    case (size)
      SizeB:   v = {8{data[7:0]}};
      SizeH:   v = {4{data[15:0]}};
      SizeW:   v = {2{data[31:0]}};
      default: v = data;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ysyx_22040127_mem_stage_load_align.sv
// Extracts the addressed load bytes from an aligned doubleword and sign/zero-extends them.
module ysyx_22040127_mem_stage_load_align
  import ysyx_22040127_mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_offset,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;
  logic            w_sext;

  always_comb begin
    w_shifted = i_rdata >> {i_offset, 3'b000};
    w_sext    = !i_unsigned;
    case (i_size)
      SizeB:   o_data = {{56{w_sext & w_shifted[7]}}, w_shifted[7:0]};
      SizeH:   o_data = {{48{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      SizeW:   o_data = {{32{w_sext & w_shifted[31]}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040127_mem_stage.sv
// MEM pipeline stage: holds one instruction, issues one data-memory request per load/store,
// and hands the aligned result to WB over a valid/allowin handshake.
module ysyx_22040127_mem_stage
  import ysyx_22040127_mem_stage_pkg::*;
#(
  parameter  int unsigned SIDE_W = 16,
  localparam int unsigned OUT_W  = SIDE_W + WB_CORE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_wen,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [SIDE_W-1:0] ex_side,
  input  logic              mem_flush,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wen,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_to_wb_valid,
  input  logic              wb_allowin,
  output logic [OUT_W-1:0]  mem_to_wb_bus
);

  mem_state_e        r_state;
  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [RD_W-1:0]   r_rd;
  logic              r_reg_wen;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_store;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [SIDE_W-1:0] r_side;
  logic [XLEN-1:0]   r_load_data;

  mem_state_e        w_state_d;
  logic              w_valid_d;
  logic              w_is_mem;
  logic              w_ready_go;
  logic              w_accept;
  logic              w_req_hs;
  logic              w_resp_take;
  logic [XLEN-1:0]   w_aligned;
  logic [XLEN-1:0]   w_reg_wdata;

  ysyx_22040127_mem_stage_load_align u_load_align (
    .i_rdata    (dmem_rdata),
    .i_offset   (r_alu[2:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_aligned)
  );

  assign w_is_mem    = r_mem_read | r_mem_write;
  assign w_ready_go  = (r_state == StDone) || ((r_state == StIdle) && !w_is_mem);
  assign mem_allowin = (r_state != StDrain) && (!r_valid || (w_ready_go && wb_allowin));
  assign w_accept    = ex_to_mem_valid && mem_allowin;
  assign w_req_hs    = (r_state == StReq) && dmem_req_ready;
  assign w_resp_take = (r_state == StResp) && dmem_resp_valid;

  assign dmem_req_valid = (r_state == StReq);
  assign dmem_req_wen   = r_mem_write;
  assign dmem_addr      = {r_alu[XLEN-1:3], 3'b000};
  assign dmem_wdata     = store_lanes(r_size, r_store);
  assign dmem_wmask     = store_mask(r_size, r_alu[2:0]);

  assign mem_to_wb_valid = r_valid && w_ready_go && (r_state != StDrain);
  assign w_reg_wdata     = r_mem_read ? r_load_data : r_alu;
  assign mem_to_wb_bus   = {r_side, r_pc, r_reg_wen, r_rd, w_reg_wdata};

  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    unique case (r_state)
      StIdle:  w_state_d = StIdle;
      StReq:   if (dmem_req_ready) w_state_d = StResp;
      StResp:  if (dmem_resp_valid) w_state_d = StDone;
      StDone:  if (wb_allowin) w_state_d = StIdle;
      StDrain: if (dmem_resp_valid) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (mem_to_wb_valid && wb_allowin) w_valid_d = 1'b0;
    // A killed instruction with a response still in flight must swallow it in DRAIN.
    if (mem_flush && r_valid) begin
      w_valid_d = 1'b0;
      if (w_req_hs || ((r_state == StResp) && !dmem_resp_valid)) w_state_d = StDrain;
      else w_state_d = StIdle;
    end
    if (w_accept) begin
      w_valid_d = 1'b1;
      w_state_d = (ex_mem_read || ex_mem_write) ? StReq : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_reg_wen   <= 1'b0;
      r_alu       <= '0;
      r_store     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_side      <= '0;
      r_load_data <= '0;
    end else begin
      r_state <= w_state_d;
      r_valid <= w_valid_d;
      if (w_accept) begin
        r_pc        <= ex_pc;
        r_rd        <= ex_rd;
        r_reg_wen   <= ex_reg_wen;
        r_alu       <= ex_alu_result;
        r_store     <= ex_store_data;
        r_mem_read  <= ex_mem_read;
        r_mem_write <= ex_mem_write;
        r_size      <= ex_mem_size;
        r_unsigned  <= ex_mem_unsigned;
        r_side      <= ex_side;
      end
      if (w_resp_take) r_load_data <= w_aligned;
    end
  end

endmodule
